// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH-1 even when WIDTH = 1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder cell.
// Latency: combinational, no state.
// Backpressure: none.
module fa_bit (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic c
);

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial A + B + cin, LSB first, one full-adder cell plus a carry flop.
// Latency: WIDTH cycles in RUN, done pulses WIDTH edges after the accepting edge.
// Backpressure: start is ignored while busy; a start during DONE reloads back-to-back.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_c;

    fa_bit u_fa (
        .s    (cell_s),
        .cout (cell_c),
        .a    (sa[0]),
        .b    (sb[0]),
        .c    (carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so bit 0 lands at sum[0] after WIDTH shifts.
                    sum   <= (sum >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
                    carry <= cell_c;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= cell_c;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: cycle-level reference model plus literal expectations.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [0:0]   s1_start;
    logic [0:0]   s1_a;
    logic [0:0]   s1_b;
    logic [0:0]   s1_cin;
    logic [0:0]   s1_busy;
    logic [0:0]   s1_done;
    logic [0:0]   s1_sum;
    logic [0:0]   s1_cout;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s1_start),
        .a     (s1_a),
        .b     (s1_b),
        .cin   (s1_cin),
        .busy  (s1_busy),
        .done  (s1_done),
        .sum   (s1_sum),
        .cout  (s1_cout)
    );

    int checks = 0;
    int errors = 0;
    int dn_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: result is plain A+B+cin, delivered WIDTH edges after acceptance.
    bit           m_init  = 1'b0;
    bit           m_busy  = 1'b0;
    bit           m_done  = 1'b0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_sum   = '0;
    logic         m_cout  = 1'b0;
    logic [W:0]   m_pend  = '0;
    int           m_left  = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init  = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_valid = 1'b1;
            m_left  = 0;
        end else if (m_init) begin
            m_done = 1'b0;
            if (start && !m_busy) begin
                m_pend  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_left  = W;
                m_busy  = 1'b1;
                m_valid = 1'b0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_sum   = m_pend[W-1:0];
                    m_cout  = m_pend[W];
                    m_valid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_done", 32'(done), 32'(m_done));
            if (m_valid) begin
                chk("model_sum", 32'(sum), 32'(m_sum));
                chk("model_cout", 32'(cout), 32'(m_cout));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) dn_cnt++;
    end

    task automatic wait_done(input string nm, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for done", nm);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input string nm);
        int cyc;
        int bcnt;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 30) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(W));
        chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(W));
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(ec), 32'(cout) ^ 32'(ec) ^ 32'(ec));
    endtask

    initial begin
        int cyc;
        int dn0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        s1_start = '0; s1_a = '0; s1_b = '0; s1_cin = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_w1_done", 32'(s1_done), 32'd0);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "add_5a_33");
        repeat (3) @(negedge clk);
        chk("hold_sum", 32'(sum), 32'h8D);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "add_cin_only");

        // Start while busy must be ignored.
        dn0 = dn_cnt;
        @(negedge clk);
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h11; b = 8'h11; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", cyc);
        chk("busy_start_sum", 32'(sum), 32'h8D);
        chk("busy_start_cout", 32'(cout), 32'd0);
        repeat (12) @(negedge clk);
        chk("busy_start_pulses", 32'(dn_cnt - dn0), 32'd1);

        // Reset in the 4th RUN cycle aborts without a done pulse.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        dn0 = dn_cnt;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", 32'(dn_cnt - dn0), 32'd0);

        // Back-to-back: restart during DONE.
        @(negedge clk);
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_first", cyc);
        chk("b2b_first_sum", 32'(sum), 32'h8D);
        a = 8'hC8; b = 8'h64; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second", cyc);
        chk("b2b_gap", 32'(cyc + 1), 32'd9);
        chk("b2b_sum", 32'(sum), 32'h2C);
        chk("b2b_cout", 32'(cout), 32'd1);

        // WIDTH = 1 instance.
        @(negedge clk);
        s1_a = 1'b1; s1_b = 1'b1; s1_cin = 1'b1; s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        chk("w1_busy", 32'(s1_busy), 32'd1);
        chk("w1_done_early", 32'(s1_done), 32'd0);
        @(negedge clk);
        chk("w1_done", 32'(s1_done), 32'd1);
        chk("w1_sum", 32'(s1_sum), 32'd1);
        chk("w1_cout", 32'(s1_cout), 32'd1);
        @(negedge clk);
        chk("w1_done_pulse", 32'(s1_done), 32'd0);
        s1_a = 1'b1; s1_b = 1'b0; s1_cin = 1'b0; s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        @(negedge clk);
        chk("w1b_done", 32'(s1_done), 32'd1);
        chk("w1b_sum", 32'(s1_sum), 32'd1);
        chk("w1b_cout", 32'(s1_cout), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
